// File: rtl/xy_scan_pkg.sv
// Shared types and helpers for the XY scan reader: FSM state, coordinate pair, raster successor.
// Sequence checking is compiled in only when XY_SCAN_CHECK_EN is defined.
package xy_scan_pkg;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    LOCKED    = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } xy_t;

  // Address/coordinate width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic xy_t xy_next(input logic [15:0] x, input logic [15:0] y,
                                  input int unsigned w, input int unsigned h);
    xy_t n;
    if (x != 16'(w - 1)) begin
      n.x = x + 16'd1;
      n.y = y;
    end else if (y != 16'(h - 1)) begin
      n.x = 16'd0;
      n.y = y + 16'd1;
    end else begin
      n.x = 16'd0;
      n.y = 16'd0;
    end
    return n;
  endfunction

endpackage

// File: rtl/xy_scan_reader_if.sv
// Bundle between the scan counter / pixel RAM / video stage and the XY scan reader.
// err_count exists only when XY_SCAN_CHECK_EN is defined.
interface xy_scan_reader_if
  import xy_scan_pkg::*;
#(
  parameter int width  = 4,
  parameter int height = 10,
  parameter int DATA_W = 8
);
  localparam int XW = clog2_min1(width);
  localparam int YW = clog2_min1(height);
  localparam int AW = clog2_min1(width * height);

  logic              enable;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              frame_start;
  logic              line_end;
  logic              locked;
  logic              seq_err;
`ifdef XY_SCAN_CHECK_EN
  logic [7:0]        err_count;

  modport slave (
    input  enable, x, y, mem_data,
    output mem_rd, mem_addr, pix_valid, pix_data, frame_start, line_end, locked, seq_err, err_count
  );
  modport master (
    output enable, x, y, mem_data,
    input  mem_rd, mem_addr, pix_valid, pix_data, frame_start, line_end, locked, seq_err, err_count
  );
`else
  modport slave (
    input  enable, x, y, mem_data,
    output mem_rd, mem_addr, pix_valid, pix_data, frame_start, line_end, locked, seq_err
  );
  modport master (
    output enable, x, y, mem_data,
    input  mem_rd, mem_addr, pix_valid, pix_data, frame_start, line_end, locked, seq_err
  );
`endif
endinterface

// File: rtl/xy_scan_expect.sv
// Holds the raster successor of the last accepted coordinate (used when XY_SCAN_CHECK_EN is defined).
module xy_scan_expect
  import xy_scan_pkg::*;
#(
  parameter int width  = 4,
  parameter int height = 10,
  localparam int XW = clog2_min1(width),
  localparam int YW = clog2_min1(height)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          upd,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output xy_t           exp_xy
);

  xy_t nxt;

  always_comb nxt = xy_next(16'(x), 16'(y), width, height);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_xy <= '0;
    end else if (upd) begin
      exp_xy <= nxt;
    end
  end

endmodule

// File: rtl/xy_scan_reader.sv
// Raster-order checker and framebuffer reader: (x,y) stream in, pixels with frame/line markers out.
// Define XY_SCAN_CHECK_EN to enable sequence checking and the saturating err_count.
module xy_scan_reader
  import xy_scan_pkg::*;
#(
  parameter int width  = 4,
  parameter int height = 10,
  parameter int DATA_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  xy_scan_reader_if.slave  bus
);

  localparam int XW = clog2_min1(width);
  localparam int AW = clog2_min1(width * height);

  state_t state_q, state_d;
  logic   acc, err_d, is00;

  logic [AW-1:0]     addr_p0;
  logic              rd_p0, fs_p0, le_p0;
  logic              vld_p1, fs_p1, le_p1;
  logic              vld_p2, fs_p2, le_p2;
  logic [DATA_W-1:0] data_p2;
  logic              err_q;

  assign is00 = (bus.x == '0) && (bus.y == '0);

`ifdef XY_SCAN_CHECK_EN
  xy_t  exp_xy;
  logic match;
  logic [7:0] err_cnt_q;

  xy_scan_expect #(.width(width), .height(height)) u_expect (
    .clock  (clock),
    .reset  (reset),
    .upd    (acc),
    .x      (bus.x),
    .y      (bus.y),
    .exp_xy (exp_xy)
  );

  assign match = (exp_xy.x == 16'(bus.x)) && (exp_xy.y == 16'(bus.y));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_count = err_cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      SYNC_WAIT: begin
        if (bus.enable && is00) begin
          acc     = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (bus.enable) begin
`ifdef XY_SCAN_CHECK_EN
          if (match) begin
            acc = 1'b1;
          end else begin
            // A stray (0,0) is still a valid frame start, so it relocks immediately.
            err_d = 1'b1;
            if (is00) acc = 1'b1;
            else      state_d = SYNC_WAIT;
          end
`else
          acc = 1'b1;
`endif
        end
      end
      default: state_d = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SYNC_WAIT;
      err_q   <= 1'b0;
      rd_p0   <= 1'b0;
      addr_p0 <= '0;
      fs_p0   <= 1'b0;
      le_p0   <= 1'b0;
      vld_p1  <= 1'b0;
      fs_p1   <= 1'b0;
      le_p1   <= 1'b0;
      vld_p2  <= 1'b0;
      fs_p2   <= 1'b0;
      le_p2   <= 1'b0;
      data_p2 <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      // p0: RAM request; address is a running count restarted by (0,0)
      rd_p0   <= acc;
      if (acc) begin
        addr_p0 <= is00 ? '0 : addr_p0 + AW'(1);
        fs_p0   <= is00;
        le_p0   <= (bus.x == XW'(width - 1));
      end
      // p1: RAM is registering the read data during this stage
      vld_p1  <= rd_p0;
      fs_p1   <= rd_p0 & fs_p0;
      le_p1   <= rd_p0 & le_p0;
      // p2: capture RAM output together with its markers
      vld_p2  <= vld_p1;
      fs_p2   <= fs_p1;
      le_p2   <= le_p1;
      if (vld_p1) data_p2 <= bus.mem_data;
    end
  end

  assign bus.mem_rd      = rd_p0;
  assign bus.mem_addr    = addr_p0;
  assign bus.pix_valid   = vld_p2;
  assign bus.pix_data    = data_p2;
  assign bus.frame_start = fs_p2;
  assign bus.line_end    = le_p2;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.seq_err     = err_q;

endmodule
